pipe_stage_elastic: RTL and testbench

- Parametrised, elastic pipeline-stage register for the five-stage CPU; successor to the fixed IF/ID latch.
- Carries an arbitrary payload (e.g. {pc, instruction}, 64 bits) between stages using a valid/ready handshake instead of a bare stall.
- Two-entry skid buffer gives full throughput with a registered-state ready_o.
- Adds flush priority, a bubble fill value, occupancy reporting and a saturating count of squashed entries.

---
 rtl/pipe_stage_elastic.sv | 125 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic two-entry pipeline stage register with flush, stall and squash count
module pipe_stage_elastic #(
  parameter int                  DATA_W     = 64,
  parameter logic [DATA_W-1:0]   BUBBLE_VAL = '0,
  parameter int                  CNT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // State encoding doubles as the occupancy value, so occ_o comes straight
  // from the state register.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               main_valid;
  logic               skid_valid;
  logic               in_fire;
  logic               out_fire;
  logic [1:0]         held;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W-1:0]   cnt_sat;

  assign main_valid = (state_q == S_ONE) || (state_q == S_FULL);
  assign skid_valid = (state_q == S_FULL);
  assign in_fire    = valid_i && ready_o;
  assign out_fire   = valid_o && ready_i;

  // Saturating squash counter: widen by one bit so the overflow is visible,
  // then clamp to all-ones.
  assign held    = {1'b0, main_valid} + {1'b0, skid_valid};
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(held);
  assign cnt_sat = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  // State and storage registers, cleared asynchronously to the bubble value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_EMPTY;
      main_q  <= BUBBLE_VAL;
      skid_q  <= BUBBLE_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-data: flush beats stall, stall freezes everything.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = S_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
      cnt_d   = cnt_sat;
    end else if (!stall_i) begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = data_i;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = data_i;
          end else if (in_fire) begin
            state_d = S_FULL;
            skid_d  = data_i;
          end else if (out_fire) begin
            state_d = S_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Handshake outputs: ready depends only on registered skid state plus the
  // stage-wide stall/flush controls, never on ready_i.
  always_comb begin
    ready_o = !skid_valid && !stall_i && !flush_i;
    valid_o = main_valid && !stall_i && !flush_i;
  end

  assign data_o      = main_q;
  assign occ_o       = state_q;
  assign flush_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed self-checking bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        stall_i;
  logic        valid_i;
  logic        ready_i;
  logic [63:0] data_i;

  logic        ready_o;
  logic        valid_o;
  logic [63:0] data_o;
  logic [1:0]  occ_o;
  logic [7:0]  flush_cnt_o;

  logic        ready_o2;
  logic        valid_o2;
  logic [15:0] data_o2;
  logic [1:0]  occ_o2;
  logic [1:0]  flush_cnt_o2;

  int n_vec;
  int n_err;

  pipe_stage_elastic #(.DATA_W(64), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .occ_o(occ_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_stage_elastic #(.DATA_W(16), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .valid_i(valid_i), .ready_o(ready_o2), .data_i(data_i[15:0]),
    .valid_o(valid_o2), .ready_i(ready_i), .data_o(data_o2),
    .occ_o(occ_o2), .flush_cnt_o(flush_cnt_o2)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    #1;
    n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL reset_occ: got %0d exp 0", occ_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b exp 0", valid_o); end
    n_vec++; if (data_o !== 64'h0) begin n_err++; $display("FAIL reset_data: got %0h exp 0", data_o); end
    n_vec++; if (flush_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d exp 0", flush_cnt_o); end
    do_reset();
  endtask

  task automatic test_stream();
    valid_i = 1'b1; ready_i = 1'b1; data_i = 64'd1;
    #1;
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready0: got %0b exp 1", ready_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL stream_valid0: got %0b exp 0", valid_o); end
    for (int i = 2; i <= 5; i++) begin
      tick();
      if (i <= 4) data_i = 64'(i);
      else valid_i = 1'b0;
      #1;
      n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %0b exp 1", i-1, valid_o); end
      n_vec++; if (data_o !== 64'(i-1)) begin n_err++; $display("FAIL stream_data[%0d]: got %0h exp %0h", i-1, data_o, i-1); end
      n_vec++; if (occ_o !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d exp 1", i-1, occ_o); end
      n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %0b exp 1", i-1, ready_o); end
    end
    tick(); #1;
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid: got %0b exp 0", valid_o); end
    n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL stream_drain_occ: got %0d exp 0", occ_o); end
    n_vec++; if (data_o !== 64'h0) begin n_err++; $display("FAIL stream_drain_data: got %0h exp 0", data_o); end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 64'h11;
    tick();
    data_i = 64'h22; #1;
    n_vec++; if (occ_o !== 2'd1) begin n_err++; $display("FAIL bp_occ1: got %0d exp 1", occ_o); end
    n_vec++; if (data_o !== 64'h11) begin n_err++; $display("FAIL bp_data1: got %0h exp 11", data_o); end
    tick();
    valid_i = 1'b0; data_i = 64'hEE; #1;
    n_vec++; if (occ_o !== 2'd2) begin n_err++; $display("FAIL bp_occ2: got %0d exp 2", occ_o); end
    n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %0b exp 0", ready_o); end
    n_vec++; if (data_o !== 64'h11) begin n_err++; $display("FAIL bp_data_held: got %0h exp 11", data_o); end
    tick(); #1;
    n_vec++; if (data_o !== 64'h11) begin n_err++; $display("FAIL bp_data_still: got %0h exp 11", data_o); end
    ready_i = 1'b1;
    tick(); #1;
    n_vec++; if (data_o !== 64'h22) begin n_err++; $display("FAIL bp_data_b: got %0h exp 22", data_o); end
    n_vec++; if (occ_o !== 2'd1) begin n_err++; $display("FAIL bp_occ_after1: got %0d exp 1", occ_o); end
    tick(); #1;
    n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL bp_occ_after2: got %0d exp 0", occ_o); end
    n_vec++; if (data_o !== 64'h0) begin n_err++; $display("FAIL bp_data_bubble: got %0h exp 0", data_o); end
  endtask

  task automatic test_stall();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 64'h33;
    tick();
    data_i = 64'h44;
    tick();
    stall_i = 1'b1; valid_i = 1'b1; data_i = 64'h99; ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL stall_valid[%0d]: got %0b exp 0", k, valid_o); end
      n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %0b exp 0", k, ready_o); end
      n_vec++; if (occ_o !== 2'd2) begin n_err++; $display("FAIL stall_occ[%0d]: got %0d exp 2", k, occ_o); end
      tick();
    end
    stall_i = 1'b0; valid_i = 1'b0; #1;
    n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL stall_rel_valid: got %0b exp 1", valid_o); end
    n_vec++; if (data_o !== 64'h33) begin n_err++; $display("FAIL stall_rel_data_a: got %0h exp 33", data_o); end
    tick(); #1;
    n_vec++; if (data_o !== 64'h44) begin n_err++; $display("FAIL stall_rel_data_b: got %0h exp 44", data_o); end
    tick(); #1;
    n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL stall_rel_occ: got %0d exp 0", occ_o); end
  endtask

  task automatic test_flush();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 64'h66;
    tick();
    data_i = 64'h77;
    tick();
    flush_i = 1'b1; stall_i = 1'b1; valid_i = 1'b1; data_i = 64'hAB; ready_i = 1'b1; #1;
    n_vec++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %0b exp 0", ready_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b exp 0", valid_o); end
    tick();
    flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0; #1;
    n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL flush_occ: got %0d exp 0", occ_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid_after: got %0b exp 0", valid_o); end
    n_vec++; if (data_o !== 64'h0) begin n_err++; $display("FAIL flush_data: got %0h exp 0", data_o); end
    n_vec++; if (flush_cnt_o !== 8'd2) begin n_err++; $display("FAIL flush_cnt: got %0d exp 2", flush_cnt_o); end
    tick(); #1;
    n_vec++; if (valid_o !== 1'b0 || data_o === 64'hAB) begin n_err++; $display("FAIL flush_drop: got valid %0b data %0h exp valid 0", valid_o, data_o); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [3];
    exp_sat[0] = 2'd2; exp_sat[1] = 2'd3; exp_sat[2] = 2'd3;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      ready_i = 1'b0; valid_i = 1'b1; data_i = 64'(r + 1);
      tick(); tick();
      #1;
      n_vec++; if (occ_o2 !== 2'd2) begin n_err++; $display("FAIL sat_occ[%0d]: got %0d exp 2", r, occ_o2); end
      flush_i = 1'b1; valid_i = 1'b0;
      tick();
      flush_i = 1'b0; #1;
      n_vec++; if (flush_cnt_o2 !== exp_sat[r]) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", r, flush_cnt_o2, exp_sat[r]); end
      n_vec++; if (flush_cnt_o !== 8'(2*(r+1))) begin n_err++; $display("FAIL wide_cnt[%0d]: got %0d exp %0d", r, flush_cnt_o, 2*(r+1)); end
    end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0; valid_i = 1'b1; data_i = 64'hC1;
    tick();
    data_i = 64'hC2;
    tick();
    valid_i = 1'b0; #1;
    n_vec++; if (occ_o !== 2'd2) begin n_err++; $display("FAIL ar_occ_pre: got %0d exp 2", occ_o); end
    #2;
    rst_i = 1'b0; #1;
    n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL ar_occ: got %0d exp 0", occ_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %0b exp 0", valid_o); end
    n_vec++; if (flush_cnt_o !== 8'd0) begin n_err++; $display("FAIL ar_cnt: got %0d exp 0", flush_cnt_o); end
    n_vec++; if (flush_cnt_o2 !== 2'd0) begin n_err++; $display("FAIL ar_cnt_sat: got %0d exp 0", flush_cnt_o2); end
    n_vec++; if (data_o !== 64'h0) begin n_err++; $display("FAIL ar_data: got %0h exp 0", data_o); end
    valid_i = 1'b1; data_i = 64'h55; ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1; #1;
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL ar_ready: got %0b exp 1", ready_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL ar_valid_pre: got %0b exp 0", valid_o); end
    tick();
    valid_i = 1'b0; #1;
    n_vec++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL ar_valid_first: got %0b exp 1", valid_o); end
    n_vec++; if (data_o !== 64'h55) begin n_err++; $display("FAIL ar_data_first: got %0h exp 55", data_o); end
    tick(); #1;
    n_vec++; if (occ_o !== 2'd0) begin n_err++; $display("FAIL ar_occ_end: got %0d exp 0", occ_o); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
